branch_rs: RTL and testbench

Branch reservation station feeding the branch unit. Holds dispatched conditional-jump micro-ops (jz/jnz/js/jns) until both operands (target `vt`, condition `va`) are available, snooping the common data bus (CDB) for producer results. Issues at most one ready op per cycle, oldest first, as registered outputs that drive the branch unit's `opcode`/`in_index`/`in_valid`/`vt`/`va` inputs directly.

---
 rtl/branch_rs_pkg.sv | 43 ++++
 rtl/branch_rs_if.sv | 39 +++
 rtl/branch_rs_select.sv | 22 ++
 rtl/branch_rs.sv | 115 +++++++++++
 tb/tb_branch_rs.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station: operand/entry/issue records
// and the CDB wake-up helper used for both resident entries and dispatch bypass.
package branch_rs_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 4;

    typedef struct packed {
        logic              ready;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } operand_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [TAG_W-1:0]  rob_index;
        operand_t          t;
        operand_t          a;
    } entry_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [TAG_W-1:0]  rob_index;
        logic [DATA_W-1:0] vt;
        logic [DATA_W-1:0] va;
    } issue_t;

    // A waiting operand captures the broadcast value when its producer tag matches.
    function automatic operand_t wake_op(operand_t op, logic cv,
                                         logic [TAG_W-1:0] ct, logic [DATA_W-1:0] cval);
        operand_t r;
        r = op;
        if (!op.ready && cv && (op.tag == ct)) begin
            r.ready = 1'b1;
            r.value = cval;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB snoop, flush and issue signals of the branch reservation station.
interface branch_rs_if;
    import branch_rs_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [TAG_W-1:0]  in_rob_index;
    logic              in_t_ready;
    logic              in_a_ready;
    logic [TAG_W-1:0]  in_t_tag;
    logic [TAG_W-1:0]  in_a_tag;
    logic [DATA_W-1:0] in_t_value;
    logic [DATA_W-1:0] in_a_value;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              flush;
    logic              out_valid;
    logic [OP_W-1:0]   out_opcode;
    logic [TAG_W-1:0]  out_rob_index;
    logic [DATA_W-1:0] out_vt;
    logic [DATA_W-1:0] out_va;

    modport master (
        output in_valid, in_opcode, in_rob_index, in_t_ready, in_a_ready,
               in_t_tag, in_a_tag, in_t_value, in_a_value,
               cdb_valid, cdb_tag, cdb_value, flush,
        input  in_ready, out_valid, out_opcode, out_rob_index, out_vt, out_va
    );

    modport slave (
        input  in_valid, in_opcode, in_rob_index, in_t_ready, in_a_ready,
               in_t_tag, in_a_tag, in_t_value, in_a_value,
               cdb_valid, cdb_tag, cdb_value, flush,
        output in_ready, out_valid, out_opcode, out_rob_index, out_vt, out_va
    );

endinterface

// File: rtl/branch_rs_select.sv
// Oldest-first priority selector: grants the lowest-index requesting slot.
module branch_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic             any
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i] & ~found;
            found    = found | req[i];
        end
        any = found;
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: collapsing age-ordered queue with CDB wake-up and
// oldest-ready issue. Define BRANCH_RS_FAST_ISSUE_EN to let ready dispatches bypass the queue.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_rs_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           ents_p0 [DEPTH];
    entry_t           ents_nxt [DEPTH];
    entry_t           woke [DEPTH+1];
    issue_t           iss_p1;
    issue_t           sel_iss;
    issue_t           inc_iss;
    entry_t           inc;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] grant;
    logic             any_rdy;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             accept;
    logic             fast;
    logic             store;
    logic             sh;

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(ents_p0[i].valid);
            rdy[i] = ents_p0[i].valid & ents_p0[i].t.ready & ents_p0[i].a.ready;
        end
    end

    assign bus.in_ready = (count < CNT_W'(DEPTH));
    assign accept       = bus.in_valid & bus.in_ready;

    branch_rs_select #(.DEPTH(DEPTH)) u_select (
        .req   (rdy),
        .grant (grant),
        .any   (any_rdy)
    );

    always_comb begin
        inc           = '0;
        inc.valid     = 1'b1;
        inc.opcode    = bus.in_opcode;
        inc.rob_index = bus.in_rob_index;
        inc.t = wake_op('{bus.in_t_ready, bus.in_t_tag, bus.in_t_value},
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        inc.a = wake_op('{bus.in_a_ready, bus.in_a_tag, bus.in_a_value},
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        inc_iss = '{1'b1, inc.opcode, inc.rob_index, inc.t.value, inc.a.value};
    end

`ifdef BRANCH_RS_FAST_ISSUE_EN
    assign fast = accept & ~any_rdy & inc.t.ready & inc.a.ready;
`else
    assign fast = 1'b0;
`endif

    assign store       = accept & ~fast;
    assign count_after = count - CNT_W'(any_rdy);

    // Wake, collapse above the granted slot, then append at the post-issue tail.
    always_comb begin
        sel_iss     = '0;
        woke[DEPTH] = '0;
        sh          = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]   = ents_p0[i];
            woke[i].t = wake_op(ents_p0[i].t, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            woke[i].a = wake_op(ents_p0[i].a, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            if (grant[i]) begin
                sel_iss = '{1'b1, ents_p0[i].opcode, ents_p0[i].rob_index,
                            ents_p0[i].t.value, ents_p0[i].a.value};
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            sh          = sh | grant[i];
            ents_nxt[i] = sh ? woke[i+1] : woke[i];
            if (store && (count_after == CNT_W'(i))) begin
                ents_nxt[i] = inc;
            end
        end
    end

    // Queue stage p0 -> issue register stage p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ents_p0[i] <= '0;
            iss_p1 <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ents_p0[i].valid <= 1'b0;
            iss_p1.valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ents_p0[i] <= ents_nxt[i];
            if (any_rdy)   iss_p1 <= sel_iss;
            else if (fast) iss_p1 <= inc_iss;
            else           iss_p1.valid <= 1'b0;
        end
    end

    assign bus.out_valid     = iss_p1.valid;
    assign bus.out_opcode    = iss_p1.opcode;
    assign bus.out_rob_index = iss_p1.rob_index;
    assign bus.out_vt        = iss_p1.vt;
    assign bus.out_va        = iss_p1.va;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed scenarios plus random traffic, checked against a
// queue-based behavioural model of the reservation station.
module tb_branch_rs;

    localparam int DEPTH = 4;
`ifdef BRANCH_RS_FAST_ISSUE_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_rs_if bus ();

    branch_rs #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rob;
        logic        tr;
        logic [3:0]  tt;
        logic [15:0] tv;
        logic        ar;
        logic [3:0]  at;
        logic [15:0] av;
    } ment_t;

    ment_t       mq[$];
    logic        exp_v;
    logic [3:0]  exp_op, exp_rob;
    logic [15:0] exp_vt, exp_va;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          d_cyc;
    logic [3:0]  iss_log[$];
    int          iss_cyc[$];
    logic [15:0] last_vt, last_va;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_v = 1'b0; exp_op = '0; exp_rob = '0; exp_vt = '0; exp_va = '0;
    endtask

    task automatic model_edge();
        ment_t inc;
        int    sel;
        bit    acc, fst;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (bus.flush) begin
            mq.delete();
            exp_v = 1'b0;
            return;
        end
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].tr && mq[i].ar) sel = i;
        acc = bus.in_valid && (mq.size() < DEPTH);
        inc.op = bus.in_opcode; inc.rob = bus.in_rob_index;
        inc.tr = bus.in_t_ready; inc.tt = bus.in_t_tag; inc.tv = bus.in_t_value;
        inc.ar = bus.in_a_ready; inc.at = bus.in_a_tag; inc.av = bus.in_a_value;
        if (!inc.tr && bus.cdb_valid && inc.tt == bus.cdb_tag) begin inc.tr = 1'b1; inc.tv = bus.cdb_value; end
        if (!inc.ar && bus.cdb_valid && inc.at == bus.cdb_tag) begin inc.ar = 1'b1; inc.av = bus.cdb_value; end
        fst = 1'b0;
`ifdef BRANCH_RS_FAST_ISSUE_EN
        fst = acc && (sel < 0) && inc.tr && inc.ar;
`endif
        if (sel >= 0) begin
            exp_v = 1'b1; exp_op = mq[sel].op; exp_rob = mq[sel].rob;
            exp_vt = mq[sel].tv; exp_va = mq[sel].av;
            mq.delete(sel);
        end else if (fst) begin
            exp_v = 1'b1; exp_op = inc.op; exp_rob = inc.rob; exp_vt = inc.tv; exp_va = inc.av;
        end else begin
            exp_v = 1'b0;
        end
        foreach (mq[i]) begin
            if (!mq[i].tr && bus.cdb_valid && mq[i].tt == bus.cdb_tag) begin mq[i].tr = 1'b1; mq[i].tv = bus.cdb_value; end
            if (!mq[i].ar && bus.cdb_valid && mq[i].at == bus.cdb_tag) begin mq[i].ar = 1'b1; mq[i].av = bus.cdb_value; end
        end
        if (acc && !fst) mq.push_back(inc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_val("out_valid", 32'(bus.out_valid), 32'(exp_v));
        check_val("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        if (exp_v) begin
            check_val("out_opcode", 32'(bus.out_opcode), 32'(exp_op));
            check_val("out_rob_index", 32'(bus.out_rob_index), 32'(exp_rob));
            check_val("out_vt", 32'(bus.out_vt), 32'(exp_vt));
            check_val("out_va", 32'(bus.out_va), 32'(exp_va));
        end
        if (bus.out_valid) begin
            iss_log.push_back(bus.out_rob_index);
            iss_cyc.push_back(cyc);
            last_vt = bus.out_vt;
            last_va = bus.out_va;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.cdb_valid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                        input logic tr, input logic [3:0] tt, input logic [15:0] tv,
                        input logic ar, input logic [3:0] at, input logic [15:0] av);
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rob_index = rob;
        bus.in_t_ready = tr; bus.in_t_tag = tt; bus.in_t_value = tv;
        bus.in_a_ready = ar; bus.in_a_tag = at; bus.in_a_value = av;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
        bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_value = val;
    endtask

    initial begin
        idle();
        disp(4'h0, 4'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        bus.in_valid = 1'b0;
        bus.cdb_tag = '0; bus.cdb_value = '0;
        model_clear();
        step(); step();
        check_val("rst_opcode", 32'(bus.out_opcode), 32'h0);
        check_val("rst_rob", 32'(bus.out_rob_index), 32'h0);
        check_val("rst_vt", 32'(bus.out_vt), 32'h0);
        check_val("rst_va", 32'(bus.out_va), 32'h0);
        rst_n = 1'b1;

        // jz with both operands ready
        iss_log.delete(); iss_cyc.delete();
        disp(4'b1000, 4'd3, 1'b1, 4'd0, 16'h0040, 1'b1, 4'd0, 16'h0000);
        step(); d_cyc = cyc; idle();
        step(); step();
        check_val("t1_count", 32'(iss_log.size()), 32'd1);
        check_val("t1_rob", 32'(iss_log[0]), 32'd3);
        check_val("t1_vt", 32'(last_vt), 32'h0040);
        check_val("t1_lat", 32'(iss_cyc[0] - d_cyc), 32'(LAT));

        // jnz waiting on tag 2
        iss_log.delete();
        disp(4'b1001, 4'd5, 1'b1, 4'd0, 16'h0100, 1'b0, 4'd2, 16'h0);
        step(); idle(); step(); step();
        check_val("t2_wait", 32'(iss_log.size()), 32'd0);
        cdb(4'd2, 16'h0007); step(); idle(); step(); step();
        check_val("t2_rob", 32'(iss_log[0]), 32'd5);
        check_val("t2_va", 32'(last_va), 32'h0007);

        // fill, ignore fifth, wake entry 2, then entries 0 and 1 together
        iss_log.delete(); iss_cyc.delete();
        disp(4'b1010, 4'd1, 1'b1, 4'd0, 16'h1, 1'b0, 4'd10, 16'h0); step();
        disp(4'b1011, 4'd2, 1'b1, 4'd0, 16'h2, 1'b0, 4'd10, 16'h0); step();
        disp(4'b1000, 4'd4, 1'b1, 4'd0, 16'h3, 1'b0, 4'd12, 16'h0); step();
        disp(4'b1001, 4'd6, 1'b1, 4'd0, 16'h4, 1'b0, 4'd13, 16'h0); step();
        check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
        disp(4'b1000, 4'd9, 1'b1, 4'd0, 16'h5, 1'b1, 4'd0, 16'h6); step(); idle();
        cdb(4'd12, 16'h1234); step(); idle(); step();
        check_val("t3_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        cdb(4'd10, 16'hABCD); step(); idle(); step(); step(); step();
        check_val("t3_count", 32'(iss_log.size()), 32'd3);
        check_val("t3_first", 32'(iss_log[0]), 32'd4);
        check_val("t3_second", 32'(iss_log[1]), 32'd1);
        check_val("t3_third", 32'(iss_log[2]), 32'd2);
        check_val("t3_back2back", 32'(iss_cyc[2] - iss_cyc[1]), 32'd1);
        check_val("t3_va", 32'(last_va), 32'hABCD);

        // dispatch bypass from a same-cycle broadcast
        iss_log.delete();
        disp(4'b1000, 4'd7, 1'b1, 4'd0, 16'h0022, 1'b0, 4'd7, 16'h0);
        cdb(4'd7, 16'hFFFF); step(); idle(); step(); step();
        check_val("t4_rob", 32'(iss_log[0]), 32'd7);
        check_val("t4_va", 32'(last_va), 32'hFFFF);

        // flush with three resident entries and a concurrent dispatch
        disp(4'b1001, 4'd11, 1'b0, 4'd14, 16'h0, 1'b1, 4'd0, 16'h9); step();
        disp(4'b1010, 4'd12, 1'b1, 4'd0, 16'h8, 1'b0, 4'd15, 16'h0); step();
        disp(4'b1011, 4'd8, 1'b1, 4'd0, 16'h7, 1'b1, 4'd0, 16'h7); bus.flush = 1'b1;
        step(); idle();
        check_val("flush_valid", 32'(bus.out_valid), 32'd0);
        check_val("flush_in_ready", 32'(bus.in_ready), 32'd1);
        iss_log.delete();
        cdb(4'd13, 16'h1); step(); cdb(4'd14, 16'h2); step(); cdb(4'd15, 16'h3); step(); idle(); step();
        check_val("flush_none", 32'(iss_log.size()), 32'd0);

        // asynchronous reset while an op is on the output
        disp(4'b1011, 4'd10, 1'b1, 4'd0, 16'h5555, 1'b1, 4'd0, 16'hAAAA); step(); idle();
        for (int k = 0; k < 3 && !exp_v; k++) step();
        check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        model_clear();
        check_val("arst_valid", 32'(bus.out_valid), 32'd0);
        check_val("arst_rob", 32'(bus.out_rob_index), 32'd0);
        check_val("arst_vt", 32'(bus.out_vt), 32'd0);
        check_val("arst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            disp(4'(8 + $urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 7)), 16'($urandom));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.cdb_valid = 1'($urandom_range(0, 1));
            bus.cdb_tag   = 4'($urandom_range(0, 7));
            bus.cdb_value = 16'($urandom);
            bus.flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
